// File: rtl/axi_noc_wr_arbiter_pkg.sv
// Shared AXI NOC write-arbiter types and constants.
// Used by the arbiter, its interface and the read path.
package axi_noc_pkg;

   localparam int AXI_ID_W = 4;
   localparam int NOC_ID_W = 6;
   localparam int NUM_M    = 4;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int STRB_W   = 4;
   localparam int LEN_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } wr_arb_state_e;

   typedef struct packed {
      logic [AXI_ID_W-1:0] id;
      logic [ADDR_W-1:0]   addr;
      logic [LEN_W-1:0]    len;
      logic [2:0]          size;
      logic [1:0]          burst;
   } aw_payload_t;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return p + 2'd1;
   endfunction

endpackage

// File: rtl/axi_noc_wr_arbiter_if.sv
// Write-path bundle between four masters, the arbiter and one slave.
// slave: arbiter view; master: environment view.
interface axi_noc_wr_arbiter_if;
   import axi_noc_pkg::*;

   logic [NUM_M-1:0]                m_awvalid;
   logic [NUM_M-1:0]                m_awready;
   logic [NUM_M-1:0][AXI_ID_W-1:0]  m_awid;
   logic [NUM_M-1:0][ADDR_W-1:0]    m_awaddr;
   logic [NUM_M-1:0][LEN_W-1:0]     m_awlen;
   logic [NUM_M-1:0][2:0]           m_awsize;
   logic [NUM_M-1:0][1:0]           m_awburst;
   logic [NUM_M-1:0]                m_wvalid;
   logic [NUM_M-1:0]                m_wlast;
   logic [NUM_M-1:0][DATA_W-1:0]    m_wdata;
   logic [NUM_M-1:0][STRB_W-1:0]    m_wstrb;
   logic [NUM_M-1:0]                m_wready;
   logic [NUM_M-1:0]                m_bvalid;
   logic [NOC_ID_W-1:0]             m_bid;
   logic [1:0]                      m_bresp;
   logic [NUM_M-1:0]                m_bready;

   logic                            s_awvalid;
   logic [NOC_ID_W-1:0]             s_awid;
   logic [ADDR_W-1:0]               s_awaddr;
   logic [LEN_W-1:0]                s_awlen;
   logic [2:0]                      s_awsize;
   logic [1:0]                      s_awburst;
   logic                            s_awready;
   logic                            s_wvalid;
   logic                            s_wlast;
   logic [DATA_W-1:0]               s_wdata;
   logic [STRB_W-1:0]               s_wstrb;
   logic                            s_wready;
   logic                            s_bvalid;
   logic [NOC_ID_W-1:0]             s_bid;
   logic [1:0]                      s_bresp;
   logic                            s_bready;

   modport slave (
      input  m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
      input  m_wvalid, m_wlast, m_wdata, m_wstrb, m_bready,
      output m_awready, m_wready, m_bvalid, m_bid, m_bresp,
      output s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
      output s_wvalid, s_wlast, s_wdata, s_wstrb, s_bready,
      input  s_awready, s_wready, s_bvalid, s_bid, s_bresp
   );

   modport master (
      output m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
      output m_wvalid, m_wlast, m_wdata, m_wstrb, m_bready,
      input  m_awready, m_wready, m_bvalid, m_bid, m_bresp,
      input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
      input  s_wvalid, s_wlast, s_wdata, s_wstrb, s_bready,
      output s_awready, s_wready, s_bvalid, s_bid, s_bresp
   );

endinterface

// File: rtl/axi_noc_wr_arbiter_rr_arbiter4.sv
// Four-way round-robin pick starting at ptr, wrapping 3->0.
// Pure combinational; shared with the read path.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] gnt_idx,
   output logic       gnt_vld
);

   logic       found;
   logic [1:0] cand;

   // first requester at or after ptr
   always_comb begin
      gnt_vld = |req;
      gnt_idx = ptr;
      found   = 1'b0;
      cand    = ptr;
      for (int i = 0; i < 4; i++) begin
         cand = ptr + 2'(i);
         if (!found && req[cand]) begin
            gnt_idx = cand;
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_noc_wr_arbiter.sv
// Write-path arbiter sharing one NOC slave port among four masters.
// AW round-robin, W locked until wlast, B routed by ID prefix.
module axi_noc_wr_arbiter #(
   parameter int NUM_M     = 4,
   parameter int MAX_OUTST = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   axi_noc_wr_arbiter_if.slave  bus
);
   import axi_noc_pkg::*;

   wr_arb_state_e    state;
   wr_arb_state_e    state_nxt;
   logic [1:0]       rr_ptr;
   logic [1:0]       grant_idx;
   logic [3:0]       outst;
   aw_payload_t      aw_q;
   aw_payload_t      aw_in;

   logic [NUM_M-1:0] req;
   logic [1:0]       gnt_idx;
   logic             gnt_vld;
   logic             can_grant;
   logic             grant_en;
   logic             aw_hs;
   logic             b_hs;
   logic [1:0]       bsel;

   logic [NUM_M-1:0] awready_c;
   logic [NUM_M-1:0] wready_c;
   logic [NUM_M-1:0] bvalid_c;
   logic             awvalid_c;
   logic             wvalid_c;
   logic             wlast_c;
   logic [31:0]      wdata_c;
   logic [3:0]       wstrb_c;

   assign req       = bus.m_awvalid;
   assign can_grant = (outst < 4'(MAX_OUTST));

   rr_arbiter4 u_rr (
      .req     (req),
      .ptr     (rr_ptr),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   assign aw_in.id    = bus.m_awid[gnt_idx];
   assign aw_in.addr  = bus.m_awaddr[gnt_idx];
   assign aw_in.len   = bus.m_awlen[gnt_idx];
   assign aw_in.size  = bus.m_awsize[gnt_idx];
   assign aw_in.burst = bus.m_awburst[gnt_idx];

   // next state and per-state channel steering
   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      awready_c = '0;
      awvalid_c = 1'b0;
      wready_c  = '0;
      wvalid_c  = 1'b0;
      wlast_c   = 1'b0;
      wdata_c   = '0;
      wstrb_c   = '0;
      unique case (state)
         ST_IDLE: begin
            if (gnt_vld && can_grant) begin
               grant_en           = 1'b1;
               awready_c[gnt_idx] = 1'b1;
               state_nxt          = ST_ADDR;
            end
         end
         ST_ADDR: begin
            awvalid_c = 1'b1;
            if (bus.s_awready) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            wvalid_c            = bus.m_wvalid[grant_idx];
            wlast_c             = bus.m_wlast[grant_idx];
            wdata_c             = bus.m_wdata[grant_idx];
            wstrb_c             = bus.m_wstrb[grant_idx];
            wready_c[grant_idx] = bus.s_wready;
            if (wvalid_c && bus.s_wready && wlast_c) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign aw_hs = (state == ST_ADDR) && bus.s_awready;

   assign bus.m_awready = awready_c;
   assign bus.s_awvalid = awvalid_c;
   assign bus.s_awid    = {grant_idx, aw_q.id};
   assign bus.s_awaddr  = aw_q.addr;
   assign bus.s_awlen   = aw_q.len;
   assign bus.s_awsize  = aw_q.size;
   assign bus.s_awburst = aw_q.burst;
   assign bus.s_wvalid  = wvalid_c;
   assign bus.s_wlast   = wlast_c;
   assign bus.s_wdata   = wdata_c;
   assign bus.s_wstrb   = wstrb_c;
   assign bus.m_wready  = wready_c;

   // B routing by the ID prefix, independent of the FSM
   always_comb begin
      bsel           = bus.s_bid[5:4];
      bvalid_c       = '0;
      bvalid_c[bsel] = bus.s_bvalid;
   end

   assign bus.m_bvalid = bvalid_c;
   assign bus.s_bready = bus.m_bready[bsel];
   assign bus.m_bid    = bus.s_bid;
   assign bus.m_bresp  = bus.s_bresp;
   assign b_hs         = bus.s_bvalid && bus.s_bready;

   // FSM state, grant latch and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rr_ptr    <= 2'd0;
         grant_idx <= 2'd0;
         aw_q      <= '0;
      end else begin
         state <= state_nxt;
         if (grant_en) begin
            grant_idx <= gnt_idx;
            aw_q      <= aw_in;
         end
         if (aw_hs) rr_ptr <= ptr_inc(grant_idx);
      end
   end

   // outstanding writes: +1 on AW, -1 on B, floor at zero
   always_ff @(posedge clk) begin
      if (rst) begin
         outst <= 4'd0;
      end else begin
         unique case ({aw_hs, b_hs})
            2'b10:   outst <= outst + 4'd1;
            2'b01:   outst <= (outst != 4'd0) ? outst - 4'd1 : 4'd0;
            default: outst <= outst;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_noc_wr_arbiter.sv
// Directed self-checking bench for axi_noc_wr_arbiter.
// Runs with MAX_OUTST = 2 so the throttle is reachable.
module tb_axi_noc_wr_arbiter;
   import axi_noc_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   exp_g;
   int   waited;

   axi_noc_wr_arbiter_if bus ();

   axi_noc_wr_arbiter #(.NUM_M(4), .MAX_OUTST(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.m_awvalid = '0;
      bus.m_awid    = '0;
      bus.m_awaddr  = '0;
      bus.m_awlen   = '0;
      bus.m_awsize  = '0;
      bus.m_awburst = '0;
      bus.m_wvalid  = '0;
      bus.m_wlast   = '0;
      bus.m_wdata   = '0;
      bus.m_wstrb   = '0;
      bus.m_bready  = '0;
      bus.s_awready = 1'b0;
      bus.s_wready  = 1'b0;
      bus.s_bvalid  = 1'b0;
      bus.s_bid     = '0;
      bus.s_bresp   = '0;
      repeat (3) cyc();
      rst = 1'b0;

      // reset state
      chk("rst_state", dut.state, ST_IDLE);
      chk("rst_outst", dut.outst, 0);
      chk("rst_awready", bus.m_awready, 0);
      chk("rst_s_awvalid", bus.s_awvalid, 0);
      chk("rst_s_wvalid", bus.s_wvalid, 0);
      chk("rst_wready", bus.m_wready, 0);
      chk("rst_bvalid", bus.m_bvalid, 0);

      // single write from M2, W presented early
      bus.m_awvalid[2] = 1'b1;
      bus.m_awid[2]    = 4'h5;
      bus.m_awaddr[2]  = 32'h1000_0040;
      bus.m_awlen[2]   = 4'd0;
      bus.m_awsize[2]  = 3'd2;
      bus.m_awburst[2] = 2'd1;
      bus.m_wvalid[2]  = 1'b1;
      bus.m_wlast[2]   = 1'b1;
      bus.m_wdata[2]   = 32'hDEAD_BEEF;
      bus.m_wstrb[2]   = 4'hF;
      bus.s_wready     = 1'b1;
      #1;
      chk("sw_awready", bus.m_awready, 4'b0100);
      chk("sw_early_wready", bus.m_wready, 0);
      cyc();
      bus.m_awvalid[2] = 1'b0;
      #1;
      chk("sw_s_awvalid", bus.s_awvalid, 1);
      chk("sw_s_awid", bus.s_awid, 6'h25);
      chk("sw_s_awaddr", bus.s_awaddr, 32'h1000_0040);
      chk("sw_addr_awready", bus.m_awready, 0);
      chk("sw_addr_wready", bus.m_wready, 0);
      bus.s_awready = 1'b1;
      cyc();
      bus.s_awready = 1'b0;
      #1;
      chk("sw_s_wvalid", bus.s_wvalid, 1);
      chk("sw_s_wdata", bus.s_wdata, 32'hDEAD_BEEF);
      chk("sw_s_wlast", bus.s_wlast, 1);
      chk("sw_wready", bus.m_wready, 4'b0100);
      chk("sw_outst1", dut.outst, 1);
      cyc();
      bus.m_wvalid[2] = 1'b0;
      #1;
      chk("sw_back_idle", dut.state, ST_IDLE);
      chk("sw_wvalid_off", bus.s_wvalid, 0);
      bus.s_bvalid = 1'b1;
      bus.s_bid    = 6'h25;
      bus.s_bresp  = 2'd0;
      bus.m_bready = 4'b0100;
      #1;
      chk("sw_bvalid", bus.m_bvalid, 4'b0100);
      chk("sw_s_bready", bus.s_bready, 1);
      chk("sw_m_bid", bus.m_bid, 6'h25);
      cyc();
      bus.s_bvalid = 1'b0;
      #1;
      chk("sw_outst0", dut.outst, 0);

      // fairness: all masters request, pointer starts at 3
      bus.m_awvalid = 4'b1111;
      bus.m_awlen   = '0;
      bus.m_wvalid  = 4'b1111;
      bus.m_wlast   = 4'b1111;
      bus.s_awready = 1'b1;
      bus.s_wready  = 1'b1;
      bus.s_bvalid  = 1'b1;
      bus.s_bid     = 6'h00;
      bus.m_bready  = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         exp_g  = (3 + k) % 4;
         waited = 0;
         #1;
         while (bus.m_awready == 0 && waited < 6) begin
            cyc();
            waited++;
         end
         chk($sformatf("fair_gnt%0d", k), bus.m_awready,
             64'(4'b0001 << exp_g));
         cyc();
      end
      bus.m_awvalid = '0;
      repeat (2) cyc();
      bus.m_wvalid = '0;
      bus.m_wlast  = '0;
      bus.s_bvalid = 1'b0;
      bus.m_bready = '0;
      #1;
      chk("fair_idle", dut.state, ST_IDLE);
      chk("fair_outst", dut.outst, 0);
      chk("fair_ptr", dut.rr_ptr, 3);

      // W lock: M1 4-beat burst while M0 holds wvalid
      bus.m_awvalid  = 4'b0010;
      bus.m_awlen[1] = 4'd3;
      bus.m_awid[1]  = 4'h7;
      bus.m_wvalid   = 4'b0011;
      bus.m_wlast    = 4'b0001;
      bus.m_wdata[0] = 32'hAAAA_0000;
      bus.m_wdata[1] = 32'h1111_0000;
      #1;
      chk("wl_gnt_m1", bus.m_awready, 4'b0010);
      cyc();
      bus.m_awvalid = 4'b0001;
      #1;
      chk("wl_addr_awready", bus.m_awready, 0);
      chk("wl_s_awlen", bus.s_awlen, 3);
      cyc();
      for (int b = 0; b < 4; b++) begin
         bus.m_wdata[1] = 32'h1111_0000 + 32'(b);
         bus.m_wlast[1] = (b == 3);
         #1;
         chk($sformatf("wl_wready%0d", b), bus.m_wready, 4'b0010);
         chk($sformatf("wl_wdata%0d", b), bus.s_wdata,
             64'(32'h1111_0000 + 32'(b)));
         cyc();
      end
      bus.m_wvalid[1] = 1'b0;
      bus.m_wlast[1]  = 1'b0;
      #1;
      chk("wl_ptr", dut.rr_ptr, 2);
      chk("wl_gnt_m0", bus.m_awready, 4'b0001);
      chk("wl_m0_held", bus.m_wready, 0);
      cyc();
      bus.m_awvalid = '0;
      cyc();
      #1;
      chk("wl_m0_wready", bus.m_wready, 4'b0001);
      chk("wl_m0_wdata", bus.s_wdata, 32'hAAAA_0000);
      cyc();
      bus.m_wvalid = '0;
      bus.m_wlast  = '0;
      #1;
      chk("wl_outst2", dut.outst, 2);

      // throttle at MAX_OUTST = 2
      bus.m_awvalid[3] = 1'b1;
      bus.m_awid[3]    = 4'h9;
      bus.m_awlen[3]   = 4'd0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("thr_block%0d", c), bus.m_awready, 0);
         cyc();
      end
      bus.s_bvalid = 1'b1;
      bus.s_bid    = 6'h10;
      bus.m_bready = 4'b0010;
      #1;
      chk("thr_bvalid", bus.m_bvalid, 4'b0010);
      cyc();
      bus.s_bvalid = 1'b0;
      #1;
      chk("thr_outst1", dut.outst, 1);
      chk("thr_gnt_m3", bus.m_awready, 4'b1000);
      cyc();
      bus.m_awvalid = '0;

      // AW and B handshake in the same cycle at outst = 1
      bus.s_bvalid = 1'b1;
      #1;
      chk("sim_pre_outst", dut.outst, 1);
      chk("sim_s_awid", bus.s_awid, 6'h39);
      cyc();
      bus.s_bvalid = 1'b0;
      bus.m_bready = '0;
      #1;
      chk("sim_outst", dut.outst, 1);
      chk("sim_state", dut.state, ST_DATA);

      // reset mid-burst in DATA
      bus.m_wvalid[3] = 1'b1;
      bus.m_wlast[3]  = 1'b0;
      #1;
      chk("rd_s_wvalid", bus.s_wvalid, 1);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("rd_s_wvalid_off", bus.s_wvalid, 0);
      chk("rd_state", dut.state, ST_IDLE);
      chk("rd_outst", dut.outst, 0);
      chk("rd_ptr", dut.rr_ptr, 0);
      bus.m_wvalid = '0;

      // B to M3 with nothing outstanding saturates at zero
      bus.s_bvalid = 1'b1;
      bus.s_bid    = 6'h3A;
      bus.s_bresp  = 2'd2;
      bus.m_bready = 4'b1000;
      #1;
      chk("bz_bvalid", bus.m_bvalid, 4'b1000);
      chk("bz_bresp", bus.m_bresp, 2);
      cyc();
      bus.s_bvalid = 1'b0;
      #1;
      chk("bz_outst", dut.outst, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
